// File: rtl/pipeline_4_writeback_if.sv
// Memory-stage to write-back bundle plus the register-file write port and forwarding outputs.
// The slave modport belongs to pipeline_4_writeback. The master modport belongs to whoever drives the memory-stage side.
interface pipeline_4_writeback_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 22,
  parameter int TYPE_W = 6,
  parameter int REG_W  = 3
);
  logic [CTRL_W-1:0] control_in;
  logic [DATA_W-1:0] result_in;
  logic [TYPE_W-1:0] inst_type_in;
  logic [DATA_W-1:0] pc_link_in;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_num;
  logic              wb_en;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_num;
  logic [DATA_W-1:0] fwd_data;
  logic              halted;
  logic              retire_pulse;

  modport slave (
    input  control_in, result_in, inst_type_in, pc_link_in, mem_rdata,
    output wb_data, wb_num, wb_en, fwd_valid, fwd_num, fwd_data, halted, retire_pulse
  );

  modport master (
    output control_in, result_in, inst_type_in, pc_link_in, mem_rdata,
    input  wb_data, wb_num, wb_en, fwd_valid, fwd_num, fwd_data, halted, retire_pulse
  );
endinterface

// File: rtl/pipeline_4_writeback.sv
// Write-back stage: registers the memory-stage word, selects the write-back value, and owns the RUN/HALT retire FSM.
// Optional macro WB_RETIRE_COUNT_EN adds a 16-bit wrapping retire_count output.
//
// state | meaning
// RUN   | stage registers capture every edge; instructions retire
// HALT  | HALT has retired; stage frozen, no writes, left only by reset
module pipeline_4_writeback #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 22,
  parameter int TYPE_W = 6,
  parameter int REG_W  = 3
) (
  input  logic clk,
  input  logic rst,
  pipeline_4_writeback_if.slave bus
`ifdef WB_RETIRE_COUNT_EN
  , output logic [15:0] retire_count
`endif
);
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] result_q;
  logic [TYPE_W-1:0] type_q;
  logic [DATA_W-1:0] pc_link_q;
  logic [DATA_W-1:0] wb_data_c;
  logic              wb_en_c;
  logic              retire_c;
  logic              halted_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      result_q  <= '0;
      type_q    <= '0;
      pc_link_q <= '0;
    end else if (state_q == RUN) begin
      ctrl_q    <= bus.control_in;
      result_q  <= bus.result_in;
      type_q    <= bus.inst_type_in;
      pc_link_q <= bus.pc_link_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // A HALT word retires in its own cycle but never writes, even if it requests a write.
  always_comb begin
    state_d  = state_q;
    wb_en_c  = 1'b0;
    retire_c = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      RUN: begin
        retire_c = |type_q;
        wb_en_c  = ctrl_q[9] && (|type_q) && !type_q[1] && !type_q[5];
        if (type_q[5]) state_d = HALT;
      end
      HALT: halted_c = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // mem_rdata is sampled live. It lines up with the registered LDR word.
  always_comb begin
    wb_data_c = result_q;
    case (ctrl_q[15:14])
      2'b01:   wb_data_c = bus.mem_rdata;
      2'b10:   wb_data_c = pc_link_q;
      default: wb_data_c = result_q;
    endcase
  end

  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_q[21:19], ctrl_q[13:10], ctrl_q[8:0]};

  assign bus.wb_data      = wb_data_c;
  assign bus.wb_num       = ctrl_q[18:16];
  assign bus.wb_en        = wb_en_c;
  assign bus.fwd_valid    = wb_en_c;
  assign bus.fwd_num      = ctrl_q[18:16];
  assign bus.fwd_data     = wb_data_c;
  assign bus.halted       = halted_c;
  assign bus.retire_pulse = retire_c;

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          retire_count <= '0;
    else if (retire_c) retire_count <= retire_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pipeline_4_writeback.sv
// Randomized and directed bench for pipeline_4_writeback against a behavioural model of the write-back rules.
module tb_pipeline_4_writeback;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_4_writeback_if bus();
`ifdef WB_RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif

  pipeline_4_writeback dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the word currently held in write-back, whether HALT has taken effect, and the retire count.
  logic [21:0] m_ctrl;
  logic [15:0] m_res, m_pc;
  logic [5:0]  m_type;
  bit          m_halt;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_res = '0; m_pc = '0; m_type = '0; m_halt = 0; m_cnt = '0;
  endtask

  task automatic model_update();
    if (!m_halt) begin
      if (m_type != 0) m_cnt = m_cnt + 16'd1;
      if (m_type[5]) m_halt = 1;
      m_ctrl = bus.control_in;
      m_res  = bus.result_in;
      m_type = bus.inst_type_in;
      m_pc   = bus.pc_link_in;
    end
  endtask

  task automatic compare();
    logic [15:0] e_data;
    bit e_en, e_ret;
    case (m_ctrl[15:14])
      2'd1:    e_data = bus.mem_rdata;
      2'd2:    e_data = m_pc;
      default: e_data = m_res;
    endcase
    e_en  = !m_halt && m_ctrl[9] && (m_type != 0) && !m_type[1] && !m_type[5];
    e_ret = !m_halt && (m_type != 0);
    chk("wb_en",        32'(bus.wb_en),        32'(e_en));
    chk("fwd_valid",    32'(bus.fwd_valid),    32'(e_en));
    chk("wb_num",       32'(bus.wb_num),       32'(m_ctrl[18:16]));
    chk("fwd_num",      32'(bus.fwd_num),      32'(m_ctrl[18:16]));
    chk("wb_data",      32'(bus.wb_data),      32'(e_data));
    chk("fwd_data",     32'(bus.fwd_data),     32'(e_data));
    chk("halted",       32'(bus.halted),       32'(m_halt));
    chk("retire_pulse", 32'(bus.retire_pulse), 32'(e_ret));
`ifdef WB_RETIRE_COUNT_EN
    chk("retire_count", 32'(retire_count),     32'(m_cnt));
`endif
  endtask

  function automatic logic [21:0] mk_ctrl(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [1:0] vsel, input logic we);
    return {op, rd, vsel, 4'b0, we, 9'b0};
  endfunction

  task automatic drive(input logic [21:0] c, input logic [15:0] r, input logic [5:0] t,
                       input logic [15:0] pc, input logic [15:0] md);
    bus.control_in = c; bus.result_in = r; bus.inst_type_in = t;
    bus.pc_link_in = pc; bus.mem_rdata = md;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
    compare();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    compare();
    chk("rst_wb_en",  32'(bus.wb_en),        32'd0);
    chk("rst_halted", 32'(bus.halted),       32'd0);
    chk("rst_data",   32'(bus.wb_data),      32'd0);
    chk("rst_retire", 32'(bus.retire_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    drive('0, '0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_wb_num", 32'(bus.wb_num), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    rst = 1'b1;

    drive(mk_ctrl(3'd1, 3'd3, 2'd0, 1'b1), 16'h1234, 6'b000001, 16'h0, 16'h0);
    cycle();
    chk("alu_en",     32'(bus.wb_en),        32'd1);
    chk("alu_num",    32'(bus.wb_num),       32'd3);
    chk("alu_data",   32'(bus.wb_data),      32'h1234);
    chk("alu_fwd",    32'(bus.fwd_valid),    32'd1);
    chk("alu_retire", 32'(bus.retire_pulse), 32'd1);

    drive(mk_ctrl(3'd2, 3'd5, 2'd1, 1'b1), 16'h0010, 6'b000100, 16'h0, 16'hBEEF);
    cycle();
    chk("ldr_data", 32'(bus.wb_data), 32'hBEEF);
    chk("ldr_num",  32'(bus.wb_num),  32'd5);
    chk("ldr_en",   32'(bus.wb_en),   32'd1);

    drive(mk_ctrl(3'd3, 3'd2, 2'd0, 1'b1), 16'h0020, 6'b000010, 16'h0, 16'h0);
    cycle();
    chk("str_en",     32'(bus.wb_en),        32'd0);
    chk("str_retire", 32'(bus.retire_pulse), 32'd1);
    drive(mk_ctrl(3'd0, 3'd4, 2'd0, 1'b1), 16'h0030, 6'b000000, 16'h0, 16'h0);
    cycle();
    chk("bub_en",     32'(bus.wb_en),        32'd0);
    chk("bub_retire", 32'(bus.retire_pulse), 32'd0);

    drive(mk_ctrl(3'd4, 3'd7, 2'd2, 1'b1), 16'h0099, 6'b010000, 16'h0042, 16'h0);
    cycle();
    chk("bl_data", 32'(bus.wb_data), 32'h0042);
    chk("bl_num",  32'(bus.wb_num),  32'd7);

    drive(mk_ctrl(3'd7, 3'd4, 2'd0, 1'b1), 16'h0055, 6'b100000, 16'h0, 16'h0);
    cycle();
    chk("halt_en",     32'(bus.wb_en),        32'd0);
    chk("halt_retire", 32'(bus.retire_pulse), 32'd1);
    chk("halt_pre",    32'(bus.halted),       32'd0);
    drive(mk_ctrl(3'd1, 3'd1, 2'd0, 1'b1), 16'h1111, 6'b000001, 16'h0, 16'h0);
    cycle();
    chk("halted",        32'(bus.halted),       32'd1);
    chk("halted_en",     32'(bus.wb_en),        32'd0);
    chk("halted_retire", 32'(bus.retire_pulse), 32'd0);
    chk("frozen_num",    32'(bus.wb_num),       32'd1);
    drive(mk_ctrl(3'd1, 3'd6, 2'd0, 1'b1), 16'h6666, 6'b000001, 16'h0, 16'h0);
    cycle();
    chk("frozen_num2",  32'(bus.wb_num),  32'd1);
    chk("frozen_data2", 32'(bus.wb_data), 32'h1111);
    chk("sticky",       32'(bus.halted),  32'd1);

    do_reset();
    drive(mk_ctrl(3'd1, 3'd2, 2'd0, 1'b1), 16'hA5A5, 6'b000001, 16'h0, 16'h0);
    cycle();
    chk("post_rst_en",   32'(bus.wb_en),   32'd1);
    chk("post_rst_num",  32'(bus.wb_num),  32'd2);
    chk("post_rst_data", 32'(bus.wb_data), 32'hA5A5);

    halt_cycles = 0;
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [5:0] t;
      if (m_halt) begin
        halt_cycles++;
        if (halt_cycles > 3) begin
          do_reset();
          halt_cycles = 0;
        end
      end
      r = int'($urandom_range(0, 39));
      if      (r < 6)  t = 6'b000000;
      else if (r < 14) t = 6'b000001;
      else if (r < 19) t = 6'b000010;
      else if (r < 27) t = 6'b000100;
      else if (r < 32) t = 6'b001000;
      else if (r < 38) t = 6'b010000;
      else             t = 6'b100000;
      drive(22'($urandom()), 16'($urandom()), t, 16'($urandom()), 16'($urandom()));
      cycle();
    end

`ifdef WB_RETIRE_COUNT_EN
    do_reset();
    drive(mk_ctrl(3'd1, 3'd1, 2'd0, 1'b1), 16'h0001, 6'b000001, 16'h0, 16'h0);
    repeat (65537) cycle();
    chk("count_wrap", 32'(retire_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
